ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 32, RAM byte-address width.
REQ-002 Parameter DW, default 32, data width; byte-enable width DW/8.
REQ-003 Parameter STARVE_MAX, default 4, max consecutive m0 grants while m1 waits.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (same level as `RstEnable).
REQ-006 arb_hold  in  1  when high, no new grants issued; a pending response still completes.
REQ-007 mX_req  in  1  request from master X; X=0 data/LSU, X=1 instruction fetch.
REQ-008 mX_we  in  1  write when high, read when low.
REQ-009 mX_addr  in  AW  byte address, word-aligned.
REQ-010 mX_wdata  in  DW  write data.
REQ-011 mX_be  in  DW/8  byte enables, writes only.
REQ-012 mX_gnt  out  1  request accepted this cycle, combinational.
REQ-013 mX_rvalid  out  1  read data valid, registered.
REQ-014 mX_rdata  out  DW  read data; 0 when mX_rvalid low.
REQ-015 ram_ce, ram_we  out  1  RAM strobe and write enable, combinational from grant.
REQ-016 ram_addr, ram_wdata, ram_be  out  AW/DW/DW8  muxed from the granted master.
REQ-017 ram_rdata  in  DW  RAM read data, valid one cycle after ram_ce with ram_we low.

Function
REQ-018 At most one of m0_gnt/m1_gnt high per cycle; no grant while arb_hold or rst low.
REQ-019 Uncontended request is granted the same cycle; ram_ce equals (m0_gnt or m1_gnt).
REQ-020 Contention (both req): m0 wins unless starve_cnt equals STARVE_MAX, then m1 wins.
REQ-021 starve_cnt increments on each m0 grant while m1_req is high; clears on m1 grant or whenever m1_req is low; saturates at STARVE_MAX.
REQ-022 Response FSM: states IDLE, RESP_M0, RESP_M1; next state RESP_mX on a read grant to mX, otherwise IDLE; evaluated every cycle.
REQ-023 In RESP_mX, mX_rvalid is high and mX_rdata equals ram_rdata; the other master's rvalid stays low.
REQ-024 Read latency from gnt to rvalid is exactly 1 cycle; back-to-back reads sustain one grant per cycle, including alternating owners.
REQ-025 Writes complete at grant; no rvalid for writes.
REQ-026 A grant in the same cycle as an outstanding response is allowed (pipelined); ordering is preserved.
REQ-027 arb_hold rising while in RESP_mX: that response is still delivered; FSM then goes IDLE.
REQ-028 Requester must hold req and payload stable until gnt; arbiter does not latch ungranted requests.

Reset
REQ-029 While rst low: all gnt, rvalid, ram_ce, ram_we low; rdata, ram_addr, ram_wdata, ram_be zero; FSM IDLE; starve_cnt 0.
REQ-030 Reset asserted mid-transaction drops any pending response; no rvalid after release until a new read is granted.
REQ-031 First grant possible in the first rising edge cycle after rst deasserts.

Structure
REQ-032 Width constants (RAM address/data bus widths, byte-enable width) live in the shared defines.v; FSM state encodings are local.
REQ-033 One sub-module ram_arbiter_pick: combinational two-way priority select with starvation override; the FSM, counter and data muxes stay in ram_arbiter.

Verification
REQ-034 m1 reads 0x100 alone (RAM holds 0xDEADBEEF) -> m1_gnt same cycle, m1_rvalid next cycle with 0xDEADBEEF, m0_rvalid stays 0.
REQ-035 m0 and m1 request continuously, STARVE_MAX=4 -> grant sequence m0,m0,m0,m0,m1 repeating; m1 never waits more than 4 cycles.
REQ-036 m0 write 0x200=0x12345678 be=0xF, next cycle m1 read 0x200 -> m1_rdata 0x12345678, no rvalid for the write.
REQ-037 Alternating reads m0@0x0, m1@0x4, m0@0x8 on consecutive cycles -> rvalid owner sequence m0,m1,m0 with correct data, zero bubbles.
REQ-038 arb_hold raised in cycle after m0 read grant -> m0_rvalid still delivered; no further grants until hold drops.
REQ-039 rst pulsed low while in RESP_M1 -> all outputs zero immediately; no m1_rvalid after release.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter: default bus widths,
// the grant-owner encoding and a counter sizing helper.
package ram_arbiter_pkg;

    localparam int RAM_AW  = 32;
    localparam int RAM_DW  = 32;
    localparam int RAM_BEW = RAM_DW / 8;

    // Which master, if any, owns the RAM port this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    // Bits needed to hold 0..max inclusive (at least one bit).
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_pick.sv
// Two-way priority select: m0 wins contention unless m1 has been starved,
// in which case m1 wins. No owner at all while disabled.
module ram_arbiter_pick
    import ram_arbiter_pkg::*;
(
    input  logic   enable,
    input  logic   m0_req,
    input  logic   m1_req,
    input  logic   starved,
    output owner_e owner
);

    // NOTE: always_comb assigns every output a default first so no path
    // through the branches leaves it unassigned and infers a latch.
    always_comb begin
        owner = OWN_NONE;
        if (enable) begin
            if (m0_req && m1_req) begin
                owner = starved ? OWN_M1 : OWN_M0;
            end else if (m0_req) begin
                owner = OWN_M0;
            end else if (m1_req) begin
                owner = OWN_M1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a data master (m0) and an instruction-fetch master (m1) onto one
// synchronous single-port RAM, with starvation protection and 1-cycle reads.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW         = RAM_AW,
    parameter int DW         = RAM_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arb_hold,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_be,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_be,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,

    output logic            ram_ce,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    output logic [DW/8-1:0] ram_be,
    input  logic [DW-1:0]   ram_rdata
);

    localparam int CW = cnt_width(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_M0 = 2'd1,
        RESP_M1 = 2'd2
    } state_e;

    state_e          state;
    owner_e          owner;
    logic [CW-1:0]   starve_cnt;
    logic            starved;

    assign starved = (starve_cnt == CW'(STARVE_MAX));

    // Reset is folded into the enable so grants are low while rst is held.
    ram_arbiter_pick u_pick (
        .enable  (rst && !arb_hold),
        .m0_req  (m0_req),
        .m1_req  (m1_req),
        .starved (starved),
        .owner   (owner)
    );

    assign m0_gnt = (owner == OWN_M0);
    assign m1_gnt = (owner == OWN_M1);
    assign ram_ce = m0_gnt || m1_gnt;

    // Idle bus is driven to zero rather than left following a master.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_be    = '0;
        unique case (owner)
            OWN_M0: begin
                ram_we    = m0_we;
                ram_addr  = m0_addr;
                ram_wdata = m0_wdata;
                ram_be    = m0_be;
            end
            OWN_M1: begin
                ram_we    = m1_we;
                ram_addr  = m1_addr;
                ram_wdata = m1_wdata;
                ram_be    = m1_be;
            end
            default: ;
        endcase
    end

    // Counts m0 wins while m1 is left waiting; any gap in m1_req forgives it.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!m1_req || m1_gnt) begin
            starve_cnt <= '0;
        end else if (m0_gnt && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Response FSM: one cycle in RESP_mX for every read granted to mX. A new
    // grant in the same cycle simply selects the next state, so reads pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (m0_gnt && !m0_we) begin
            state <= RESP_M0;
        end else if (m1_gnt && !m1_we) begin
            state <= RESP_M1;
        end else begin
            state <= IDLE;
        end
    end

    assign m0_rvalid = (state == RESP_M0);
    assign m1_rvalid = (state == RESP_M1);
    assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

    a_one_grant : assert property (@(posedge clk) disable iff (!rst)
        !(m0_gnt && m1_gnt));
    a_one_rvalid : assert property (@(posedge clk) disable iff (!rst)
        !(m0_rvalid && m1_rvalid));
    a_cnt_bound : assert property (@(posedge clk) disable iff (!rst)
        starve_cnt <= CW'(STARVE_MAX));

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model and a behavioural RAM.
module tb_ram_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int SMAX  = 4;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          arb_hold;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [BW-1:0] m0_be;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [BW-1:0] m1_be;
    logic          ram_ce, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [BW-1:0] ram_be;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .arb_hold  (arb_hold),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_be     (m0_be),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_be     (m1_be),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_be    (ram_be),
        .ram_rdata (ram_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h9E37_79B1);
    endfunction

    // Behavioural synchronous RAM sitting on the arbiter's RAM port.
    logic [DW-1:0] ram_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = init_word(i);
        ram_mem[8'h40] = 32'hDEAD_BEEF;
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (ram_ce) begin
                if (ram_we) begin
                    for (int b = 0; b < BW; b++)
                        if (ram_be[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end else begin
                    ram_rdata <= ram_mem[ram_addr[9:2]];
                end
            end
        end
    end

    // Reference model state: shadow memory, starvation streak, expected response.
    logic [DW-1:0] model_mem [DEPTH];
    int            streak;
    bit            exp_rv0, exp_rv1, last_g0, last_g1;
    logic [DW-1:0] exp_rd;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        for (int b = 0; b < BW; b++)
            if (be[b]) model_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic model_reset();
        streak  = 0;
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        exp_rd  = '0;
        last_g0 = 1'b0;
        last_g1 = 1'b0;
    endtask

    task automatic drive_idle();
        arb_hold = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    endtask

    // Called just after a rising edge with inputs already driven: checks this
    // cycle's grant and RAM strobe, advances the model, then checks the response.
    task automatic step(input string tag);
        bit g0, g1;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst && !arb_hold) begin
            if (m0_req && m1_req) begin
                if (streak >= SMAX) g1 = 1'b1;
                else g0 = 1'b1;
            end else if (m0_req) begin
                g0 = 1'b1;
            end else if (m1_req) begin
                g1 = 1'b1;
            end
        end
        check({tag, ".m0_gnt"}, m0_gnt, g0);
        check({tag, ".m1_gnt"}, m1_gnt, g1);
        check({tag, ".ram_ce"}, ram_ce, g0 | g1);
        if (g0 || g1) begin
            check({tag, ".ram_we"}, ram_we, g0 ? m0_we : m1_we);
            check({tag, ".ram_addr"}, ram_addr, g0 ? m0_addr : m1_addr);
            if (ram_we) begin
                check({tag, ".ram_wdata"}, ram_wdata, g0 ? m0_wdata : m1_wdata);
                check({tag, ".ram_be"}, ram_be, g0 ? m0_be : m1_be);
            end
        end
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        exp_rd  = '0;
        if (g0) begin
            if (m0_we) model_write(m0_addr, m0_wdata, m0_be);
            else begin exp_rv0 = 1'b1; exp_rd = model_mem[m0_addr[9:2]]; end
        end
        if (g1) begin
            if (m1_we) model_write(m1_addr, m1_wdata, m1_be);
            else begin exp_rv1 = 1'b1; exp_rd = model_mem[m1_addr[9:2]]; end
        end
        if (!m1_req || g1) streak = 0;
        else if (g0 && streak < SMAX) streak++;
        last_g0 = g0;
        last_g1 = g1;
        @(posedge clk);
        #1;
        check({tag, ".m0_rvalid"}, m0_rvalid, exp_rv0);
        check({tag, ".m1_rvalid"}, m1_rvalid, exp_rv1);
        check({tag, ".m0_rdata"}, m0_rdata, exp_rv0 ? exp_rd : '0);
        check({tag, ".m1_rdata"}, m1_rdata, exp_rv1 ? exp_rd : '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gnt"}, {m0_gnt, m1_gnt}, 2'b00);
        check({tag, ".rvalid"}, {m0_rvalid, m1_rvalid}, 2'b00);
        check({tag, ".rdata"}, m0_rdata | m1_rdata, '0);
        check({tag, ".ram_ce_we"}, {ram_ce, ram_we}, 2'b00);
        check({tag, ".ram_bus"}, ram_addr | ram_wdata | 32'(ram_be), '0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);
        model_mem[8'h40] = 32'hDEAD_BEEF;
        model_reset();
        drive_idle();

        // Reset holds everything quiet even with both masters requesting.
        rst = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h10;
        m1_req = 1'b1; m1_addr = 32'h20;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        drive_idle();
        rst = 1'b1;

        // m1 alone reads 0x100, granted in the first cycle after release.
        m1_req = 1'b1; m1_addr = 32'h100;
        step("m1_alone");
        check("m1_alone.data", m1_rdata, 32'hDEAD_BEEF);
        drive_idle();
        step("idle0");

        // Continuous contention: m0 x4 then m1, repeating.
        m0_req = 1'b1; m0_addr = 32'h10;
        m1_req = 1'b1; m1_addr = 32'h20;
        for (int i = 0; i < 15; i++) begin
            #1;
            check("starve_seq", {m0_gnt, m1_gnt}, (i % 5 == 4) ? 2'b01 : 2'b10);
            step("contend");
        end
        drive_idle();
        step("idle1");

        // Write then read back from the other master; partial byte enables.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h200; m0_wdata = 32'h1234_5678; m0_be = 4'hF;
        step("wr200");
        drive_idle();
        m1_req = 1'b1; m1_addr = 32'h200;
        step("rd200");
        check("rd200.data", m1_rdata, 32'h1234_5678);
        drive_idle();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h204; m1_wdata = 32'hCAFE_F00D; m1_be = 4'h5;
        step("wr204_be5");
        drive_idle();
        m0_req = 1'b1; m0_addr = 32'h204;
        step("rd204");
        drive_idle();

        // Alternating owners on consecutive cycles, no bubbles.
        m0_req = 1'b1; m0_addr = 32'h0;
        step("alt0");
        drive_idle();
        m1_req = 1'b1; m1_addr = 32'h4;
        step("alt1");
        drive_idle();
        m0_req = 1'b1; m0_addr = 32'h8;
        step("alt2");
        drive_idle();
        step("idle2");

        // Hold raised right after a read grant: response still arrives.
        m0_req = 1'b1; m0_addr = 32'h40;
        step("hold_rd");
        arb_hold = 1'b1;
        m1_req = 1'b1; m1_addr = 32'h44;
        step("hold1");
        step("hold2");
        arb_hold = 1'b0;
        step("hold_rel");
        drive_idle();
        step("idle3");

        // Reset pulse while a response to m1 is outstanding.
        m1_req = 1'b1; m1_addr = 32'h100;
        step("pre_rst");
        rst = 1'b0;
        #1;
        check_all_zero("rst_pulse");
        @(posedge clk);
        #1;
        drive_idle();
        rst = 1'b1;
        model_reset();
        step("post_rst0");
        step("post_rst1");

        // Random traffic; each master holds its request until granted.
        for (int c = 0; c < 400; c++) begin
            if (!m0_req || last_g0) begin
                m0_req   = ($urandom_range(0, 9) < 6);
                m0_we    = ($urandom_range(0, 2) == 0);
                m0_addr  = {22'b0, 8'($urandom_range(0, 63)), 2'b00};
                m0_wdata = $urandom;
                m0_be    = 4'($urandom_range(0, 15));
            end
            if (!m1_req || last_g1) begin
                m1_req   = ($urandom_range(0, 9) < 6);
                m1_we    = ($urandom_range(0, 3) == 0);
                m1_addr  = {22'b0, 8'($urandom_range(0, 63)), 2'b00};
                m1_wdata = $urandom;
                m1_be    = 4'($urandom_range(0, 15));
            end
            arb_hold = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
